read_arbiter: RTL

Round-robin arbiter and sequencer that shares a single rd/ack read state machine among N requesters. It accepts per-requester read requests and grants exactly one at a time. It drives the four-phase rd/ack handshake toward the shared reader, captures the returned data, and signals completion or timeout back to the granted requester. It sits between the requester blocks and the existing read state machine, whose rd input and ack/rd_data outputs it owns.

---
 rtl/read_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/read_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/read_arb_pkg.sv
// Shared types and defaults for the read arbiter and its helpers.
package read_arb_pkg;

    // Arbiter FSM states; 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Cycles allowed in READ or HOLD before the transaction is aborted.
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [PW:0]   pos;
    logic [PW-1:0] cand;

    // Walk offsets 0..N-1 from ptr; the smallest offset with a request wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
            cand = pos[PW-1:0];
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_arbiter.sv
// Round-robin owner of the shared rd/ack reader: grants one requester at a
// time, runs the four-phase handshake, captures data, reports done or timeout.
module read_arbiter
    import read_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          rd,
    input  logic          ack,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] data_out,
    output logic [N-1:0]  done,
    output logic          err
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_d;
    logic [PW-1:0] ptr, ptr_d, owner, owner_d, ptr_nxt;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic          cnt_max;
    logic [N-1:0]  gnt_d, done_d;
    logic          rd_d, err_d;
    logic [DW-1:0] data_d;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Timeout counter compare/saturating increment and next search start.
    assign cnt_max = (cnt == CW'(TIMEOUT));
    assign cnt_inc = cnt_max ? cnt : cnt + CW'(1);
    assign ptr_nxt = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        owner_d = owner;
        cnt_d   = cnt;
        gnt_d   = gnt;
        rd_d    = rd;
        done_d  = '0;
        err_d   = 1'b0;
        data_d  = data_out;
        case (state)
            ST_IDLE: begin
                // ack seen here is stale from a previous reader cycle; ignore it.
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_onehot;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // ack wins over timeout when both land on the same edge.
                if (ack) begin
                    data_d  = rd_data;
                    done_d  = gnt;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_max) begin
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HOLD: begin
                // Wait for the reader to drop ack before releasing the grant.
                if (!ack || cnt_max) begin
                    err_d   = ack;
                    ptr_d   = ptr_nxt;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                gnt_d   = '0;
                rd_d    = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs; reset drops rd/gnt at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            gnt      <= '0;
            rd       <= 1'b0;
            done     <= '0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            owner    <= owner_d;
            cnt      <= cnt_d;
            gnt      <= gnt_d;
            rd       <= rd_d;
            done     <= done_d;
            err      <= err_d;
            data_out <= data_d;
        end
    end

endmodule
